// File: rtl/imem_loader.sv
// Byte-stream program loader: writes a length-prefixed image big-endian into instruction memory from address 0,
// holding the processor until the image is complete. Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module imem_loader #(
    parameter int ADDR_W    = 10,
    parameter int MAX_WORDS = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              error
);

    typedef enum logic [2:0] {
        S_LEN_HI = 3'd0,
        S_LEN_LO = 3'd1,
        S_DATA   = 3'd2,
        S_CSUM   = 3'd3,
        S_FIN    = 3'd4,
        S_DONE   = 3'd5,
        S_ERR    = 3'd6
    } state_t;

    localparam logic [15:0] MAX_N = 16'(MAX_WORDS);

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_t AFTER_PAYLOAD = S_CSUM;

    function automatic logic [7:0] csum_fold(input logic [7:0] acc, input logic [7:0] b);
        csum_fold = acc ^ b;
    endfunction
`else
    localparam state_t AFTER_PAYLOAD = S_FIN;
`endif

    state_t            state_r;
    state_t            state_nxt_s;
    logic [7:0]        len_hi_r;
    logic [ADDR_W:0]   total_r;
    logic [ADDR_W-1:0] cnt_r;
    logic              ready_r;
    logic              we_r;
    logic [ADDR_W-1:0] addr_r;
    logic [7:0]        wdata_r;
    logic              hold_r;
    logic              done_r;
    logic              error_r;
    logic              xfer_s;
    logic [15:0]       len_s;
    logic [ADDR_W:0]   cnt_inc_s;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]        csum_r;
`endif

    // Handshake: the ready flag tracks the registered state but is forced low while reset is held.
    assign in_ready  = ready_r & ~rst;
    assign xfer_s    = in_valid & in_ready;
    assign len_s     = {len_hi_r, in_data};
    assign cnt_inc_s = {1'b0, cnt_r} + {{ADDR_W{1'b0}}, 1'b1};

    assign mem_we    = we_r;
    assign mem_addr  = addr_r;
    assign mem_wdata = wdata_r;
    assign cpu_hold  = hold_r;
    assign done      = done_r;
    assign error     = error_r;

    // Next-state decode for the load sequence.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_LEN_HI: begin
                if (xfer_s) begin
                    state_nxt_s = S_LEN_LO;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            S_LEN_LO: begin
                if (!xfer_s) begin
                    state_nxt_s = state_r;
                end else if (len_s == 16'd0) begin
                    state_nxt_s = AFTER_PAYLOAD;
                end else if (len_s > MAX_N) begin
                    state_nxt_s = S_ERR;
                end else begin
                    state_nxt_s = S_DATA;
                end
            end
            S_DATA: begin
                // The count is one behind the byte being taken, so compare the incremented value.
                if (xfer_s && (cnt_inc_s == total_r)) begin
                    state_nxt_s = AFTER_PAYLOAD;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            S_CSUM: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                if (!xfer_s) begin
                    state_nxt_s = state_r;
                end else if (in_data == csum_r) begin
                    state_nxt_s = S_FIN;
                end else begin
                    state_nxt_s = S_ERR;
                end
`else
                state_nxt_s = S_ERR;
`endif
            end
            S_FIN:   state_nxt_s = S_DONE;
            S_DONE:  state_nxt_s = S_DONE;
            S_ERR:   state_nxt_s = S_ERR;
            default: state_nxt_s = S_ERR;
        endcase
    end

    // State, counters and registered outputs; status flags trail the state by one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= S_LEN_HI;
            len_hi_r <= 8'd0;
            total_r  <= '0;
            cnt_r    <= '0;
            ready_r  <= 1'b1;
            we_r     <= 1'b0;
            addr_r   <= '0;
            wdata_r  <= 8'd0;
            hold_r   <= 1'b1;
            done_r   <= 1'b0;
            error_r  <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_r   <= 8'd0;
`endif
        end else begin
            state_r <= state_nxt_s;
            ready_r <= (state_nxt_s == S_LEN_HI) || (state_nxt_s == S_LEN_LO) ||
                       (state_nxt_s == S_DATA)   || (state_nxt_s == S_CSUM);
            done_r  <= (state_r == S_DONE);
            error_r <= (state_r == S_ERR);
            hold_r  <= (state_r != S_DONE);

            if (xfer_s && (state_r == S_LEN_HI)) begin
                len_hi_r <= in_data;
            end else begin
                len_hi_r <= len_hi_r;
            end

            if (xfer_s && (state_r == S_LEN_LO)) begin
                total_r <= {len_s[ADDR_W-2:0], 2'b00};
            end else begin
                total_r <= total_r;
            end

            if (xfer_s && (state_r == S_DATA)) begin
                we_r    <= 1'b1;
                addr_r  <= cnt_r;
                wdata_r <= in_data;
                cnt_r   <= cnt_r + {{(ADDR_W-1){1'b0}}, 1'b1};
            end else begin
                we_r    <= 1'b0;
                addr_r  <= addr_r;
                wdata_r <= wdata_r;
                cnt_r   <= cnt_r;
            end

`ifdef IMEM_LOADER_CHECKSUM_EN
            if (xfer_s && ((state_r == S_LEN_HI) || (state_r == S_LEN_LO) || (state_r == S_DATA))) begin
                csum_r <= csum_fold(csum_r, in_data);
            end else begin
                csum_r <= csum_r;
            end
`endif
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected memory writes are queued as payload is sent and
// checked by a monitor whenever mem_we is seen; status outputs are checked directly.
module tb_imem_loader;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       mem_we;
    logic [9:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       cpu_hold;
    logic       done;
    logic       error;

    logic [17:0] sb[$];
    int          tests = 0;
    int          fails = 0;
    int          exp_addr = 0;
    logic [7:0]  cks = 8'd0;

    imem_loader #(.ADDR_W(10), .MAX_WORDS(256)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .cpu_hold (cpu_hold),
        .done     (done),
        .error    (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every write strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_write: addr %0h data %0h, expected no write", mem_addr, mem_wdata);
            end else begin
                logic [17:0] e;
                e = sb.pop_front();
                check("write_addr", 32'(mem_addr), 32'(e[17:8]));
                check("write_data", 32'(mem_wdata), 32'(e[7:0]));
            end
        end
    end

    task automatic send(input logic [7:0] b);
        int t;
        t = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (in_ready !== 1'b1 && t < 20) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 20) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: byte %02h not accepted, in_ready=%b expected 1", b, in_ready);
        end else begin
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        cks = cks ^ b;
    endtask

    task automatic hdr(input logic [15:0] n);
        cks = 8'd0;
        exp_addr = 0;
        send(n[15:8]);
        send(n[7:0]);
    endtask

    task automatic pay(input logic [7:0] b);
        sb.push_back({10'(exp_addr), b});
        exp_addr++;
        send(b);
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("rst_in_ready_low", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        check("rst_cpu_hold", 32'(cpu_hold), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        exp_addr = 0;
    endtask

    // Ends a good image: FIN cycle, then done/release exactly two edges after the final byte.
    task automatic finish_ok(input string tag);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send(cks);
`endif
        check({tag, "_fin_done"}, 32'(done), 32'd0);
        check({tag, "_fin_ready"}, 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        check({tag, "_k1_done"}, 32'(done), 32'd0);
        check({tag, "_k1_hold"}, 32'(cpu_hold), 32'd1);
        @(posedge clk); #1;
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_hold"}, 32'(cpu_hold), 32'd0);
        check({tag, "_error"}, 32'(error), 32'd0);
        check({tag, "_ready"}, 32'(in_ready), 32'd0);
        check({tag, "_writes_left"}, 32'(sb.size()), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = 8'd0;

        // 1: one word
        do_reset();
        hdr(16'h0001);
        pay(8'h20); pay(8'h08); pay(8'h00); pay(8'h05);
        finish_ok("t1");
        in_valid = 1'b1; in_data = 8'h77;
        @(posedge clk); #1;
        check("t1_no_accept_done", 32'(in_ready), 32'd0);
        in_valid = 1'b0;

        // 2: two words with idle gaps between bytes
        do_reset();
        hdr(16'h0002);
        pay(8'hDE); @(posedge clk); #1;
        pay(8'hAD); @(posedge clk); #1;
        pay(8'hBE); @(posedge clk); #1;
        pay(8'hEF); @(posedge clk); #1;
        pay(8'h01); @(posedge clk); #1;
        pay(8'h23); @(posedge clk); #1;
        pay(8'h45); @(posedge clk); #1;
        pay(8'h67);
        finish_ok("t2");

        // 3: oversize header
        do_reset();
        hdr(16'h0101);
        check("t3_ready_after_hdr", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        check("t3_error", 32'(error), 32'd1);
        check("t3_hold", 32'(cpu_hold), 32'd1);
        check("t3_done", 32'(done), 32'd0);
        in_valid = 1'b1; in_data = 8'h55;
        repeat (4) @(posedge clk);
        #1;
        check("t3_ready", 32'(in_ready), 32'd0);
        check("t3_error_sticky", 32'(error), 32'd1);
        in_valid = 1'b0;

        // 4: maximum legal length header boundary (N=256) is not tested fully; N=0 is
        do_reset();
        hdr(16'h0000);
        finish_ok("t4");

        // 5: reset mid-payload, then a full image
        do_reset();
        hdr(16'h0001);
        pay(8'h11); pay(8'h22); pay(8'h33);
        do_reset();
        hdr(16'h0001);
        pay(8'hAA); pay(8'hBB); pay(8'hCC); pay(8'hDD);
        finish_ok("t5");

`ifdef IMEM_LOADER_CHECKSUM_EN
        // 6: checksum good (45) then bad (46)
        do_reset();
        hdr(16'h0001);
        pay(8'h11); pay(8'h22); pay(8'h33); pay(8'h44);
        check("t6_cks_model", 32'(cks), 32'h45);
        finish_ok("t6");
        do_reset();
        hdr(16'h0001);
        pay(8'h11); pay(8'h22); pay(8'h33); pay(8'h44);
        send(8'h46);
        @(posedge clk); #1;
        check("t6_bad_error", 32'(error), 32'd1);
        check("t6_bad_hold", 32'(cpu_hold), 32'd1);
        check("t6_bad_done", 32'(done), 32'd0);
`endif

        repeat (3) @(posedge clk);
        #1;
        check("final_writes_left", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
